// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch sequencer.
// Imported by inst_fetch_ctrl and fetch_tag_fifo.
package inst_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;
  localparam logic [31:0] ZeroWord     = 32'h00000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_tag_fifo.sv
// PC tag FIFO for accepted fetch requests; same-cycle push and pop.
// Overflow is prevented upstream by the outstanding-request limit.
module fetch_tag_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  assign o_head = r_mem[r_rptr];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch PC sequencer: SRAM-like request handshake, PC tagging, credit throttle.
// Optional perf counters under `FETCH_PERF_CNT_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          IBUF_DEPTH      = 32,
  localparam int         FW              = $clog2(IBUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  input  logic          branch_flag,
  input  logic [31:0]   branch_target,
  input  logic [FW-1:0] ibuf_free,
  output logic          inst_req,
  output logic [31:0]   inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [31:0]   inst_rdata,
  output logic          buf_push,
  output logic [31:0]   buf_inst,
  output logic [31:0]   buf_pc,
  output logic          buf_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   perf_req_cnt,
  output logic [31:0]   perf_discard_cnt,
  output logic [31:0]   perf_credit_stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_redir_pc;
  logic          r_redir_pend;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [CW-1:0] w_live;
  logic [CW-1:0] w_out_nxt;
  logic          w_credit_ok;
  logic          w_redir;
  logic [31:0]   w_tgt;
  logic          w_acc;
  logic          w_held;
  logic          w_dok;
  logic          w_drop;
  logic [31:0]   w_tag_head;

  assign w_live      = r_out - r_disc;
  assign w_credit_ok = (32'(w_live) < 32'(ibuf_free)) &&
                       (r_out < CW'(MAX_OUTSTANDING));

  always_comb begin
    w_state_nxt = r_state;
    inst_req    = 1'b0;
    unique case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        inst_req = w_credit_ok;
        if (w_credit_ok && !inst_addr_ok) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        inst_req = 1'b1;
        if (inst_addr_ok) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign inst_addr = r_fetch_pc;
  assign w_acc     = inst_req & inst_addr_ok;
  assign w_held    = inst_req & ~inst_addr_ok;
  assign w_redir   = flush | branch_flag;
  assign w_tgt     = flush ? flush_pc : branch_target;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_dok     = inst_data_ok & (r_out != '0);
  assign w_drop    = w_dok & ((r_disc != '0) | w_redir);
  assign w_out_nxt = r_out + CW'(w_acc) - CW'(w_dok);

  assign buf_push  = w_dok & ~w_drop;
  assign buf_inst  = inst_rdata;
  assign buf_pc    = w_tag_head;
  assign buf_flush = w_redir;

  fetch_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (32)
  ) u_tag_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_acc),
    .i_din  (inst_addr),
    .i_pop  (w_dok),
    .o_head (w_tag_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= ZeroWord;
      r_redir_pend <= 1'b0;
      r_out        <= '0;
      r_disc       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      // A held request accepted after a redirect belongs to the old stream.
      if (w_redir) r_disc <= w_out_nxt;
      else r_disc <= r_disc - CW'(w_drop) + CW'(w_acc & r_redir_pend);
      if (w_redir && w_held) begin
        r_redir_pend <= 1'b1;
        r_redir_pc   <= w_tgt;
      end else if (w_redir) begin
        r_redir_pend <= 1'b0;
        r_fetch_pc   <= w_tgt;
      end else if (w_acc) begin
        r_redir_pend <= 1'b0;
        r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + 32'd4;
      end
    end
  end

  a_no_spurious_data: assert property (
    @(posedge clk) disable iff (reset) !(inst_data_ok && r_out == '0)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_req;
  logic [31:0] r_perf_disc;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_req   <= '0;
      r_perf_disc  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_acc && r_perf_req != '1) r_perf_req <= r_perf_req + 32'd1;
      if (w_drop && r_perf_disc != '1) r_perf_disc <= r_perf_disc + 32'd1;
      if (r_state == S_FETCH && !w_credit_ok && r_perf_stall != '1)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_req_cnt          = r_perf_req;
  assign perf_discard_cnt      = r_perf_disc;
  assign perf_credit_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: scenario tasks plus a randomized
// run against a queue-based model of the request/response streams.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RPC = 32'hbfc00000;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [5:0]  ibuf_free = 6'd32;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        buf_push;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        buf_flush;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ibuf_free     (ibuf_free),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .inst_rdata    (inst_rdata),
    .buf_push      (buf_push),
    .buf_inst      (buf_inst),
    .buf_pc        (buf_pc),
    .buf_flush     (buf_flush)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] q_addr[$];
  bit          q_stale[$];
  logic [31:0] model_pc;
  bit          held_old;
  bit          prev_hold;
  logic [31:0] prev_addr;
  int          occ;
  int          cap = 32;

  bit          o_req, o_push, o_flush;
  logic [31:0] o_addr, o_pc, o_inst;
  bit          e_push, e_redir, was_hold, acc, dok_now;
  logic [31:0] e_pc, hold_addr, exp_new;
  int          n_acc, n_push, n_silent;
  bit          got_fresh, got_push;
  logic [31:0] first_fresh, first_push;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h13579bdf;
  endfunction

  task automatic model_clear();
    q_addr.delete();
    q_stale.delete();
    model_pc  = RPC;
    held_old  = 1'b0;
    prev_hold = 1'b0;
    prev_addr = '0;
    occ       = 0;
    n_acc     = 0;
    n_push    = 0;
    n_silent  = 0;
    got_fresh = 1'b0;
    got_push  = 1'b0;
  endtask

  task automatic idle_inputs();
    flush         = 1'b0;
    flush_pc      = '0;
    branch_flag   = 1'b0;
    branch_target = '0;
    inst_addr_ok  = 1'b0;
    inst_data_ok  = 1'b0;
    inst_rdata    = '0;
    ibuf_free     = 6'(cap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Drives one cycle of memory/redirect stimulus and advances the model.
  task automatic cycle(input bit aok, input bit dok, input bit fl,
                       input logic [31:0] fpc, input bit br,
                       input logic [31:0] bt, input int pop_pct);
    logic [31:0] a;
    logic [31:0] tgt;
    bit          s;
    @(posedge clk);
    #1;
    dok_now       = dok && (q_addr.size() > 0);
    inst_addr_ok  = aok;
    inst_data_ok  = dok_now;
    inst_rdata    = dok_now ? memf(q_addr[0]) : 32'h0;
    flush         = fl;
    flush_pc      = fpc;
    branch_flag   = br;
    branch_target = bt;
    ibuf_free     = 6'(cap - occ);
    @(negedge clk);
    o_req   = inst_req;
    o_addr  = inst_addr;
    o_push  = buf_push;
    o_pc    = buf_pc;
    o_inst  = buf_inst;
    o_flush = buf_flush;
    e_redir   = fl | br;
    tgt       = fl ? fpc : bt;
    was_hold  = prev_hold;
    hold_addr = prev_addr;
    exp_new   = model_pc;
    e_push    = 1'b0;
    e_pc      = '0;
    if (dok_now) begin
      a = q_addr.pop_front();
      s = q_stale.pop_front();
      if (!s && !e_redir) begin
        e_push = 1'b1;
        e_pc   = a;
      end
      if (!o_push) n_silent++;
    end
    acc = o_req && aok;
    if (acc) begin
      s = held_old || e_redir;
      q_addr.push_back(o_addr);
      q_stale.push_back(s);
      n_acc++;
      if (!s && !got_fresh) begin
        got_fresh   = 1'b1;
        first_fresh = o_addr;
      end
      if (!s) model_pc = exp_new + 32'd4;
      held_old = 1'b0;
    end
    if (o_push) begin
      occ++;
      n_push++;
      if (!got_push) begin
        got_push   = 1'b1;
        first_push = o_pc;
      end
    end
    if (e_redir) begin
      model_pc = tgt;
      if (!acc && o_req) held_old = 1'b1;
      foreach (q_stale[i]) q_stale[i] = 1'b1;
      occ = 0;
    end
    prev_hold = o_req && !aok;
    prev_addr = o_addr;
    if (occ > 0 && int'($urandom_range(99)) < pop_pct) occ--;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #3;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_req got=%b exp=0", inst_req);
    end
    checks++;
    if (inst_addr !== RPC) begin
      failures++;
      $display("FAIL rst_addr got=%h exp=%h", inst_addr, RPC);
    end
    checks++;
    if (buf_push !== 1'b0) begin
      failures++;
      $display("FAIL rst_push got=%b exp=0", buf_push);
    end
    checks++;
    if (buf_flush !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush got=%b exp=0", buf_flush);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    #2;
    checks++;
    if (inst_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_req got=%b exp=0", inst_req);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/%h", o_req, o_addr, RPC);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc_a[$];
    int          acc_c[$];
    logic [31:0] push_a[$];
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
      if (acc) begin
        acc_a.push_back(o_addr);
        acc_c.push_back(c);
      end
      if (o_push) push_a.push_back(o_pc);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (acc_a.size() <= i || acc_a[i] !== RPC + 32'(4 * i)) begin
        failures++;
        $display("FAIL b2b_addr%0d got=%h exp=%h", i,
                 (acc_a.size() > i) ? acc_a[i] : 32'hx, RPC + 32'(4 * i));
      end
      checks++;
      if (acc_c.size() <= i || acc_c[i] !== i) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%0d exp=%0d", i,
                 (acc_c.size() > i) ? acc_c[i] : -1, i);
      end
      checks++;
      if (push_a.size() <= i || push_a[i] !== RPC + 32'(4 * i)) begin
        failures++;
        $display("FAIL b2b_pc%0d got=%h exp=%h", i,
                 (push_a.size() > i) ? push_a[i] : 32'hx, RPC + 32'(4 * i));
      end
    end
    checks++;
    if (n_silent !== 0) begin
      failures++;
      $display("FAIL b2b_discards got=%0d exp=0", n_silent);
    end
  endtask

  task automatic test_credit();
    cap = 2;
    do_reset();
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 0);
    checks++;
    if (n_acc !== 2) begin
      failures++;
      $display("FAIL credit_acc got=%0d exp=2", n_acc);
    end
    checks++;
    if (o_req !== 1'b0) begin
      failures++;
      $display("FAIL credit_req got=%b exp=0", o_req);
    end
    checks++;
    if (n_push !== 2) begin
      failures++;
      $display("FAIL credit_push got=%0d exp=2", n_push);
    end
    cap = 32;
  endtask

  task automatic test_branch();
    int exp_drop;
    do_reset();
    for (int c = 0; c < 10 && n_acc < 3; c++)
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h80001000, 0);
    exp_drop = q_addr.size();
    checks++;
    if (o_flush !== 1'b1) begin
      failures++;
      $display("FAIL br_flush got=%b exp=1", o_flush);
    end
    for (int c = 0; c < 30; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
    checks++;
    if (n_silent !== exp_drop) begin
      failures++;
      $display("FAIL br_discards got=%0d exp=%0d", n_silent, exp_drop);
    end
    checks++;
    if (!got_push || first_push !== 32'h80001000) begin
      failures++;
      $display("FAIL br_first_pc got=%h exp=80001000", first_push);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h00400000, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RPC || o_flush !== 1'b1) begin
      failures++;
      $display("FAIL hold_redir got=%b/%h/%b exp=1/%h/1",
               o_req, o_addr, o_flush, RPC);
    end
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RPC) begin
      failures++;
      $display("FAIL hold_stable got=%b/%h exp=1/%h", o_req, o_addr, RPC);
    end
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    checks++;
    if (!acc || o_addr !== RPC) begin
      failures++;
      $display("FAIL hold_accept got=%b/%h exp=1/%h", acc, o_addr, RPC);
    end
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
    checks++;
    if (!got_fresh || first_fresh !== 32'h00400000) begin
      failures++;
      $display("FAIL hold_next_addr got=%h exp=00400000", first_fresh);
    end
    checks++;
    if (n_silent !== 1) begin
      failures++;
      $display("FAIL hold_discards got=%0d exp=1", n_silent);
    end
    checks++;
    if (!got_push || first_push !== 32'h00400000) begin
      failures++;
      $display("FAIL hold_first_pc got=%h exp=00400000", first_push);
    end
  endtask

  task automatic test_flush_prio();
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
    got_fresh = 1'b0;
    got_push  = 1'b0;
    cycle(1'b0, 1'b1, 1'b1, 32'hbfc00380, 1'b1, 32'h12345678, 50);
    checks++;
    if (o_flush !== 1'b1) begin
      failures++;
      $display("FAIL prio_flush got=%b exp=1", o_flush);
    end
    for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
    checks++;
    if (!got_fresh || first_fresh !== 32'hbfc00380) begin
      failures++;
      $display("FAIL prio_addr got=%h exp=bfc00380", first_fresh);
    end
    checks++;
    if (!got_push || first_push !== 32'hbfc00380) begin
      failures++;
      $display("FAIL prio_first_pc got=%h exp=bfc00380", first_push);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c < 10 && n_acc < 2; c++)
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 0);
    #2;
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++;
    if (inst_req !== 1'b0 || inst_addr !== RPC) begin
      failures++;
      $display("FAIL arst_req got=%b/%h exp=0/%h", inst_req, inst_addr, RPC);
    end
    checks++;
    if (buf_push !== 1'b0 || buf_flush !== 1'b0) begin
      failures++;
      $display("FAIL arst_buf got=%b/%b exp=0/0", buf_push, buf_flush);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 50);
    checks++;
    if (!got_fresh || first_fresh !== RPC) begin
      failures++;
      $display("FAIL arst_restart got=%h exp=%h", first_fresh, RPC);
    end
    checks++;
    if (!got_push || first_push !== RPC || n_silent !== 0) begin
      failures++;
      $display("FAIL arst_first_pc got=%h/%0d exp=%h/0",
               first_push, n_silent, RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] rt;
    logic [31:0] rf;
    int          r;
    bit          fl;
    bit          br;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(99));
      fl = (r < 2);
      br = (r >= 1 && r < 5);
      rt = $urandom;
      rt[1:0] = 2'b00;
      rf = $urandom;
      rf[1:0] = 2'b00;
      cycle(int'($urandom_range(99)) < 60, int'($urandom_range(99)) < 55,
            fl, rf, br, rt, 35);
      if (was_hold) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== hold_addr) begin
          failures++;
          $display("FAIL rnd_hold c=%0d got=%b/%h exp=1/%h",
                   c, o_req, o_addr, hold_addr);
        end
      end else if (o_req) begin
        checks++;
        if (o_addr !== exp_new) begin
          failures++;
          $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, o_addr, exp_new);
        end
      end
      checks++;
      if (o_push !== e_push) begin
        failures++;
        $display("FAIL rnd_push c=%0d got=%b exp=%b", c, o_push, e_push);
      end
      if (e_push) begin
        checks++;
        if (o_pc !== e_pc || o_inst !== memf(e_pc)) begin
          failures++;
          $display("FAIL rnd_data c=%0d got=%h/%h exp=%h/%h",
                   c, o_pc, o_inst, e_pc, memf(e_pc));
        end
      end
      checks++;
      if (o_flush !== e_redir) begin
        failures++;
        $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, o_flush, e_redir);
      end
      checks++;
      if (q_addr.size() > MAXO || occ > cap) begin
        failures++;
        $display("FAIL rnd_limits c=%0d got=%0d/%0d exp<=%0d/%0d",
                 c, q_addr.size(), occ, MAXO, cap);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_credit();
    test_branch();
    test_hold_redirect();
    test_flush_prio();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch-side sequencer in front of the instruction buffer.
- Generates the fetch PC and drives the SRAM-like instruction request handshake (req/addr_ok/data_ok).
- Tags every accepted request with its PC, pushes returned instructions plus PC into the buffer, and throttles issue by buffer credit.
- On flush or branch: redirects, clears the buffer, and silently drops all in-flight responses of the old stream.

Parameters:
- RESET_PC, 32'hbfc00000, first fetch address after reset.
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned requests (power of 2, >=2).
- IBUF_DEPTH, 32, instruction buffer capacity; sets ibuf_free width = clog2(IBUF_DEPTH+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  exception/eret redirect, highest priority
- flush_pc  in  32  target for flush
- branch_flag  in  1  branch-taken redirect from decode
- branch_target  in  32  target for branch
- ibuf_free  in  clog2(IBUF_DEPTH+1)  free slots currently in the buffer
- inst_req  out  1  request valid
- inst_addr  out  32  request address (word aligned)
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  response valid this cycle (in order)
- inst_rdata  in  32  response data
- buf_push  out  1  write one entry into the buffer
- buf_inst  out  32  instruction to write
- buf_pc  out  32  PC of that instruction
- buf_flush  out  1  clear the buffer (one cycle pulse)

Behaviour:
- Reset:
  - inst_req=0, inst_addr=RESET_PC, fetch_pc=RESET_PC.
  - buf_push=0, buf_flush=0.
  - outstanding_cnt=0, discard_cnt=0, tag FIFO empty, state=S_IDLE.
- States:
  - S_IDLE: one cycle after reset, then S_FETCH.
  - S_FETCH: inst_req=1 when credit_ok; otherwise inst_req=0.
  - S_HOLD: request issued and not yet accepted. inst_req=1, inst_addr stable, no change allowed until inst_addr_ok.
- credit_ok = (outstanding_cnt - discard_cnt) < ibuf_free && outstanding_cnt < MAX_OUTSTANDING.
- Request flow:
  - Raising inst_req enters S_HOLD unless inst_addr_ok arrives in the same cycle.
  - On inst_addr_ok: push inst_addr into the tag FIFO, outstanding_cnt++, fetch_pc += 4, return to S_FETCH.
  - Back-to-back accepts allowed: one per cycle.
- Response:
  - On inst_data_ok: pop the tag FIFO and decrement outstanding_cnt.
  - If discard_cnt != 0 or a redirect occurs this cycle: discard_cnt-- where nonzero, buf_push=0.
  - Otherwise buf_push=1, buf_inst=inst_rdata, buf_pc=tag head. Combinational, zero latency.
- Redirect (flush has priority over branch_flag; target = flush_pc or branch_target):
  - buf_flush=1 in the same cycle.
  - fetch_pc <= target.
  - discard_cnt <= outstanding_cnt + accept_this_cycle - dataok_this_cycle, then any old-stream entries counted.
  - Redirect in S_HOLD without addr_ok: the held request stays unchanged until accepted and is counted for discard. Target is parked in redirect_pc (pending flag); fetch_pc takes it at acceptance.
  - A second redirect while one is pending overwrites redirect_pc.
- Simultaneous accept + data_ok: counters net to zero change. The tag FIFO push and pop in the same cycle are both performed.
- Boundary conditions:
  - Tag FIFO full cannot occur because of the MAX_OUTSTANDING gate.
  - inst_data_ok with outstanding_cnt==0 is a protocol error: ignored, and flagged by an assertion.
  - ibuf_free==0 stops new issue; an already held request still completes.
- Arithmetic: fetch_pc wraps modulo 2^32. All counters are clog2(MAX_OUTSTANDING)+1 bits.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds three 32-bit saturating counters, cleared on reset, with outputs perf_req_cnt, perf_discard_cnt, perf_credit_stall_cnt:
  - accepted requests;
  - discarded responses;
  - cycles in S_FETCH with credit_ok=0.
- When undefined, the ports are absent and there is no logic.

Decomposition:
- Shared defines header: RESET_PC value, state encodings (S_IDLE/S_FETCH/S_HOLD), and the ZeroWord constant.
- One sub-module, fetch_tag_fifo: MAX_OUTSTANDING x 32 synchronous FIFO with same-cycle push/pop and async reset of its pointers.

Test Plan:
- Reset release, addr_ok tied 1, data_ok one cycle later, ibuf_free=32 -> addresses bfc00000, bfc00004, bfc00008 issued back to back; buf_pc matches each; no discards.
- Hold ibuf_free=2, never pop, 2 responses returned -> exactly 2 requests accepted; inst_req=0 afterwards; perf stall counter increments (if enabled).
- 3 outstanding, branch_flag with target 80001000 -> buf_flush pulse; next 3 data_ok give buf_push=0; first pushed buf_pc=80001000.
- Redirect in S_HOLD, addr_ok 2 cycles later -> inst_addr unchanged through the hold; that response is discarded; next request addr=redirect target.
- flush and branch_flag in the same cycle, flush_pc=bfc00380 -> next fetch is bfc00380.
- Async reset asserted mid-burst with 2 outstanding -> outputs return to reset values immediately; after release, fetch restarts at RESET_PC with nothing stale pushed.
